// File: rtl/mul_host_pkg.sv
// Shared types and default sizing for the serial-multiplier host driver.
package mul_host_pkg;

  localparam int unsigned OpWDefault     = 12;
  localparam int unsigned ResWDefault    = 24;
  localparam int unsigned TimeoutDefault = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StShiftOps,
    StWaitFull,
    StMul,
    StWaitDone,
    StShiftRes,
    StResult
  } state_e;

endpackage

// File: rtl/mul_host_if.sv
// Host-side operand/result handshake plus serial multiplier link.
// master = the driver, slave = host/multiplier environment.
interface mul_host_if
  import mul_host_pkg::*;
#(
  parameter int unsigned OP_W  = OpWDefault,
  parameter int unsigned RES_W = ResWDefault
) ();

  logic [OP_W-1:0]  x_op;
  logic [OP_W-1:0]  y_op;
  logic             start;
  logic             ready;
  logic             x_in;
  logic             y_in;
  logic             sx;
  logic             sy;
  logic             fx;
  logic             fy;
  logic             mul;
  logic             done;
  logic             sz;
  logic             z_out;
  logic             fz;
  logic [RES_W-1:0] res;
  logic             res_valid;
  logic             res_ready;
  logic             err;

  modport master (
    input  x_op, y_op, start, fx, fy, done, z_out, fz, res_ready,
    output ready, x_in, y_in, sx, sy, mul, sz, res, res_valid, err
  );

  modport slave (
    output x_op, y_op, start, fx, fy, done, z_out, fz, res_ready,
    input  ready, x_in, y_in, sx, sy, mul, sz, res, res_valid, err
  );

endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out, MSB first; the first bit appears the cycle after load.
module piso_tx #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         bit_o,
  output logic         last_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    sreg_q, sreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bit_q, bit_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    bit_d  = 1'b0;
    if (load_i) begin
      bit_d  = data_i[W-1];
      sreg_d = data_i << 1;
      cnt_d  = CntW'(1);
    end else if (shift_i && (cnt_q < CntW'(W))) begin
      bit_d  = sreg_q[W-1];
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      bit_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
    end
  end

  // cnt_q == W while the last bit is on the line
  assign bit_o  = bit_q;
  assign last_o = (cnt_q == CntW'(W));

endmodule

// File: rtl/mul_host_driver.sv
// Sequences one signed multiply on a bit-serial multiplier and returns the product.
// Optional watchdog on the handshake waits: define MUL_HOST_TIMEOUT_EN.
module mul_host_driver
  import mul_host_pkg::*;
#(
  parameter int unsigned OP_W    = OpWDefault,
  parameter int unsigned RES_W   = ResWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic        clk,
  input logic        rst,
  mul_host_if.master bus_io
);

  localparam int unsigned CntW = $clog2(RES_W + 1);
  localparam logic [CntW-1:0] ResLast = CntW'(RES_W);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             fx_seen_q, fx_seen_d;
  logic             fy_seen_q, fy_seen_d;
  logic             sx_q, sx_d;
  logic             mul_q, mul_d;
  logic             sz_q, sz_d;
  logic             load, shift;
  logic             x_last, y_last;

`ifdef MUL_HOST_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           fz_seen_q, fz_seen_d;
  logic           err_q, err_d;
`endif

  piso_tx #(.W(OP_W)) u_x_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus_io.x_op),
    .bit_o   (bus_io.x_in),
    .last_o  (x_last)
  );

  piso_tx #(.W(OP_W)) u_y_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus_io.y_op),
    .bit_o   (bus_io.y_in),
    .last_o  (y_last)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    fx_seen_d = fx_seen_q;
    fy_seen_d = fy_seen_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          load    = 1'b1;
          state_d = StShiftOps;
        end
      end
      StShiftOps: begin
        shift     = 1'b1;
        fx_seen_d = 1'b0;
        fy_seen_d = 1'b0;
        if (x_last && y_last) state_d = StWaitFull;
      end
      StWaitFull: begin
        fx_seen_d = fx_seen_q | bus_io.fx;
        fy_seen_d = fy_seen_q | bus_io.fy;
        if (fx_seen_d && fy_seen_d) state_d = StMul;
      end
      StMul: state_d = StWaitDone;
      StWaitDone: begin
        if (bus_io.done) begin
          state_d = StShiftRes;
          cnt_d   = '0;
        end
      end
      StShiftRes: begin
        // z_out lags sz by one cycle, so sampling starts at count 1
        if (cnt_q != '0) res_d = {res_q[RES_W-2:0], bus_io.z_out};
        if (cnt_q == ResLast) state_d = StResult;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StResult: begin
        if (bus_io.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef MUL_HOST_TIMEOUT_EN
    err_d     = err_q;
    wd_d      = '0;
    fz_seen_d = 1'b0;
    if (state_q inside {StWaitFull, StWaitDone, StShiftRes}) begin
      fz_seen_d = fz_seen_q | (bus_io.fz && (state_q == StShiftRes));
      if (state_d == state_q) wd_d = wd_q + WdW'(1);
      if ((wd_q == WdW'(TIMEOUT - 1)) ||
          ((state_q == StShiftRes) && (cnt_q == ResLast) && !(fz_seen_q | bus_io.fz))) begin
        err_d   = 1'b1;
        state_d = StIdle;
        wd_d    = '0;
      end
    end
`endif

    sx_d  = (state_d == StShiftOps);
    mul_d = (state_d == StMul);
    sz_d  = (state_d == StShiftRes) && (cnt_d < ResLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      res_q     <= '0;
      fx_seen_q <= 1'b0;
      fy_seen_q <= 1'b0;
      sx_q      <= 1'b0;
      mul_q     <= 1'b0;
      sz_q      <= 1'b0;
`ifdef MUL_HOST_TIMEOUT_EN
      wd_q      <= '0;
      fz_seen_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      fx_seen_q <= fx_seen_d;
      fy_seen_q <= fy_seen_d;
      sx_q      <= sx_d;
      mul_q     <= mul_d;
      sz_q      <= sz_d;
`ifdef MUL_HOST_TIMEOUT_EN
      wd_q      <= wd_d;
      fz_seen_q <= fz_seen_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus_io.ready     = (state_q == StIdle);
  assign bus_io.res_valid = (state_q == StResult);
  assign bus_io.res       = res_q;
  assign bus_io.sx        = sx_q;
  assign bus_io.sy        = sx_q;
  assign bus_io.mul       = mul_q;
  assign bus_io.sz        = sz_q;
`ifdef MUL_HOST_TIMEOUT_EN
  assign bus_io.err       = err_q;
`else
  assign bus_io.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mul_host_driver.sv
// Bench for mul_host_driver with a behavioural bit-serial multiplier on the far side.
module tb_mul_host_driver;
  import mul_host_pkg::*;

  localparam int OP_W  = 12;
  localparam int RES_W = 24;
  localparam int BASE_LAT = OP_W + RES_W + 4;
`ifdef MUL_HOST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_host_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

  mul_host_driver #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Multiplier model: collects serial operands, raises flags after programmable delays.
  int fx_dly = 0, fy_dly = 0, done_dly = 0;
  int xn, yn, fx_cd, fy_cd, d_cd, zn;
  logic [OP_W-1:0]  mx, my;
  logic [RES_W-1:0] mprod;

  always @(posedge clk) begin
    if (rst) begin
      xn <= 0; yn <= 0; zn <= 0; fx_cd <= 0; fy_cd <= 0; d_cd <= 0;
      bus.fx <= 1'b0; bus.fy <= 1'b0; bus.done <= 1'b0; bus.z_out <= 1'b0; bus.fz <= 1'b0;
    end else begin
      if (bus.sx) begin
        mx <= {mx[OP_W-2:0], bus.x_in};
        xn <= xn + 1;
        if (xn == OP_W - 1) begin
          if (fx_dly == 0) bus.fx <= 1'b1;
          else fx_cd <= fx_dly;
        end
      end else if (fx_cd > 0) begin
        fx_cd <= fx_cd - 1;
        if (fx_cd == 1) bus.fx <= 1'b1;
      end
      if (bus.sy) begin
        my <= {my[OP_W-2:0], bus.y_in};
        yn <= yn + 1;
        if (yn == OP_W - 1) begin
          if (fy_dly == 0) bus.fy <= 1'b1;
          else fy_cd <= fy_dly;
        end
      end else if (fy_cd > 0) begin
        fy_cd <= fy_cd - 1;
        if (fy_cd == 1) bus.fy <= 1'b1;
      end
      if (bus.mul) begin
        bus.fx <= 1'b0; bus.fy <= 1'b0; bus.fz <= 1'b0;
        xn <= 0; yn <= 0; zn <= 0;
        mprod <= RES_W'(int'($signed(mx)) * int'($signed(my)));
        if (done_dly == 0) bus.done <= 1'b1;
        else d_cd <= done_dly;
      end else if (d_cd > 0) begin
        d_cd <= d_cd - 1;
        if (d_cd == 1) bus.done <= 1'b1;
      end
      if (bus.sz) begin
        bus.done  <= 1'b0;
        bus.z_out <= mprod[RES_W-1];
        mprod     <= mprod << 1;
        zn        <= zn + 1;
        if (zn == RES_W - 1) bus.fz <= 1'b1;
      end
    end
  end

  // Line monitor: serial bit history and pulse counts
  int sx_cnt = 0, sy_cnt = 0, mul_cnt = 0;
  logic [31:0] xbits = '0, ybits = '0;
  always @(negedge clk) begin
    if (bus.sx) begin sx_cnt <= sx_cnt + 1; xbits <= {xbits[30:0], bus.x_in}; end
    if (bus.sy) begin sy_cnt <= sy_cnt + 1; ybits <= {ybits[30:0], bus.y_in}; end
    if (bus.mul) mul_cnt <= mul_cnt + 1;
  end

  function automatic logic [RES_W-1:0] ref_prod(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
    return RES_W'(int'($signed(x)) * int'($signed(y)));
  endfunction

  // Run one multiply, leave the result pending, check everything up to res_valid
  task automatic run_mul(input string tag, input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                         input int fxd, input int fyd, input int dd,
                         input logic [RES_W-1:0] exp_res, input int exp_lat);
    int n, lat, b_sx, b_sy, b_mul;
    fx_dly = fxd; fy_dly = fyd; done_dly = dd;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready_idle"}, bus.ready, 1);
    @(negedge clk);
    b_sx = sx_cnt; b_sy = sy_cnt; b_mul = mul_cnt;
    bus.x_op = x; bus.y_op = y; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.res_valid !== 1'b1 && lat < 500);
    chk({tag, "_res"}, bus.res, exp_res);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_sx_cycles"}, sx_cnt - b_sx, OP_W);
    chk({tag, "_sy_cycles"}, sy_cnt - b_sy, OP_W);
    chk({tag, "_mul_pulses"}, mul_cnt - b_mul, 1);
    chk({tag, "_x_serial"}, xbits[OP_W-1:0], x);
    chk({tag, "_y_serial"}, ybits[OP_W-1:0], y);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ready_after_hs"}, bus.ready, 1);
    chk({tag, "_valid_after_hs"}, bus.res_valid, 0);
    @(negedge clk); bus.res_ready = 1'b0;
  endtask

  typedef struct {
    logic [OP_W-1:0]  x;
    logic [OP_W-1:0]  y;
    int               fxd;
    int               fyd;
    int               dd;
    logic [RES_W-1:0] exp_res;
    int               exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [OP_W-1:0] rx, ry;
    int rfx, rfy, rd;
    bus.start = 1'b0; bus.x_op = '0; bus.y_op = '0; bus.res_ready = 1'b0;
    vecs[0] = '{12'h003, 12'hFFB, 0, 0, 0,  24'hFFFFF1, BASE_LAT};
    vecs[1] = '{12'h800, 12'h800, 0, 0, 0,  24'h400000, BASE_LAT};
    vecs[2] = '{12'h064, 12'hFDB, 0, 5, 20, 24'hFFF18C, BASE_LAT + 25};
    vecs[3] = '{12'h7FF, 12'h7FF, 0, 0, 0,  24'h3FF001, BASE_LAT};
    vecs[4] = '{12'h800, 12'h7FF, 3, 1, 2,  24'hC00800, BASE_LAT + 5};
    vecs[5] = '{12'h000, 12'hFFF, 0, 0, 0,  24'h000000, BASE_LAT};
    vecs[6] = '{12'hFFF, 12'hFFF, 2, 0, 0,  24'h000001, BASE_LAT + 2};
    vecs[7] = '{12'h007, 12'h007, 0, 0, 0,  24'h000031, BASE_LAT};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_sx_sy", {bus.sx, bus.sy}, 0);
    chk("rst_x_y_in", {bus.x_in, bus.y_in}, 0);
    chk("rst_mul_sz", {bus.mul, bus.sz}, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk); rst = 1'b0;

`ifndef MUL_HOST_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].fxd, vecs[i].fyd,
              vecs[i].dd, vecs[i].exp_res, vecs[i].exp_lat);
      handshake($sformatf("vec%0d", i));
    end

    // Reset during the 6th operand-shift cycle
    @(negedge clk); bus.x_op = 12'h003; bus.y_op = 12'hFFB; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("s4_sx_before_rst", bus.sx, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s4_ready", bus.ready, 1);
    chk("s4_sx", bus.sx, 0);
    chk("s4_valid", bus.res_valid, 0);
    chk("s4_res_cleared", bus.res, 0);
    @(negedge clk); rst = 1'b0;
    run_mul("s4_after", 12'h007, 12'h007, 0, 0, 0, 24'h000031, BASE_LAT);
    handshake("s4_after");

    // Back-pressure with start held high
    run_mul("s5", 12'h123, 12'h045, 0, 0, 0, 24'h004E6F, BASE_LAT);
    begin
      int b_sx;
      @(negedge clk); bus.start = 1'b1; bus.x_op = 12'h7FF; bus.y_op = 12'h001;
      b_sx = sx_cnt;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        chk($sformatf("s5_res_c%0d", c), bus.res, 24'h004E6F);
        chk($sformatf("s5_valid_c%0d", c), bus.res_valid, 1);
        chk($sformatf("s5_sx_c%0d", c), bus.sx, 0);
      end
      @(negedge clk); bus.res_ready = 1'b1; bus.start = 1'b0;
      @(posedge clk); #1;
      chk("s5_ready_after_hs", bus.ready, 1);
      chk("s5_no_shift", sx_cnt - b_sx, 0);
      @(negedge clk); bus.res_ready = 1'b0;
    end

    for (int i = 0; i < 16; i++) begin
      rx = OP_W'($urandom); ry = OP_W'($urandom);
      rfx = $urandom_range(0, 3); rfy = $urandom_range(0, 3); rd = $urandom_range(0, 4);
      run_mul($sformatf("rnd%0d", i), rx, ry, rfx, rfy, rd, ref_prod(rx, ry),
              BASE_LAT + ((rfx > rfy) ? rfx : rfy) + rd);
      handshake($sformatf("rnd%0d", i));
    end
`else
    // Watchdog: done never arrives
    begin
      int n;
      done_dly = 100000;
      @(negedge clk); bus.x_op = 12'h003; bus.y_op = 12'h005; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      n = 0;
      while (bus.mul !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("s6_mul_seen", bus.mul, 1);
      @(posedge clk);
      repeat (15) @(posedge clk);
      #1;
      chk("s6_err_before", bus.err, 0);
      @(posedge clk); #1;
      chk("s6_err_set", bus.err, 1);
      chk("s6_idle", bus.ready, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("s6_err_sticky", bus.err, 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("s6_err_cleared", bus.err, 0);
      @(negedge clk); rst = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
